// File: rtl/maxnet_sequencer.sv
// Control sequencer for the 4-neuron MaxNet winner-take-all datapath.
// Start/busy/done handshake with an iteration cap and a timeout flag.
module maxnet_sequencer #(
    parameter int MAX_ITER    = 16,
    parameter int MULT_CYCLES = 1,
    parameter int ITER_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              single,
    output logic              read,
    output logic              ld_y,
    output logic              slc_y,
    output logic              ld_mult,
    output logic              ld_sum,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);
    localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(MULT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_X, S_INIT_Y, S_MULT, S_WAIT,
        S_SUM, S_CHECK, S_UPDATE, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_LOAD_X;
            S_LOAD_X:       state_nxt = S_INIT_Y;
            S_INIT_Y:       state_nxt = S_MULT;
            S_MULT:         state_nxt = (MULT_CYCLES == 1) ? S_SUM : S_WAIT;
            S_WAIT:         if (wait_cnt <= CNT_W'(1)) state_nxt = S_SUM;
            S_SUM:          state_nxt = S_CHECK;
            // convergence wins over the cap on the final pass
            S_CHECK: begin
                if (single)                       state_nxt = S_DONE;
                else if (iter_count == ITER_MAX)  state_nxt = S_DONE;
                else                              state_nxt = S_UPDATE;
            end
            S_UPDATE:       state_nxt = S_MULT;
            default:        state_nxt = S_IDLE;
        endcase
    end

    assign read    = (state == S_LOAD_X);
    assign ld_y    = (state == S_INIT_Y) || (state == S_UPDATE);
    assign slc_y   = (state == S_UPDATE);
    assign ld_mult = (state == S_MULT);
    assign ld_sum  = (state == S_SUM);
    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign done    = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_count <= '0;
            timeout    <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    iter_count <= '0;
                    timeout    <= 1'b0;
                end
                S_MULT:  wait_cnt <= WAIT_INIT;
                S_WAIT:  wait_cnt <= wait_cnt - CNT_W'(1);
                S_SUM:   if (iter_count < ITER_MAX) iter_count <= iter_count + ITER_W'(1);
                S_CHECK: timeout <= !single && (iter_count == ITER_MAX);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_maxnet_sequencer.sv
// Bench for maxnet_sequencer: two instances (single-cycle and 3-cycle multiplier)
// checked cycle by cycle against a pass-level schedule model.
module tb_maxnet_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start0 = 1'b0, single0 = 1'b0, start1 = 1'b0, single1 = 1'b0;
    wire  [7:0] v0, v1;
    wire  [2:0] iter0, iter1;
    int checks = 0;
    int errors = 0;

    // expected vector layout: {read, ld_y, slc_y, ld_mult, ld_sum, busy, done, timeout}
    typedef struct {
        logic [7:0] v;
        logic [2:0] it;
        bit         chk;
        int         pass;
    } step_t;
    step_t exp_q[$];

    always #5 clk = ~clk;

    maxnet_sequencer #(.MAX_ITER(4), .MULT_CYCLES(1), .ITER_W(3)) u0 (
        .clk(clk), .rst(rst), .start(start0), .single(single0),
        .read(v0[7]), .ld_y(v0[6]), .slc_y(v0[5]), .ld_mult(v0[4]), .ld_sum(v0[3]),
        .busy(v0[2]), .done(v0[1]), .timeout(v0[0]), .iter_count(iter0));

    maxnet_sequencer #(.MAX_ITER(5), .MULT_CYCLES(3), .ITER_W(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .single(single1),
        .read(v1[7]), .ld_y(v1[6]), .slc_y(v1[5]), .ld_mult(v1[4]), .ld_sum(v1[3]),
        .busy(v1[2]), .done(v1[1]), .timeout(v1[0]), .iter_count(iter1));

    task automatic check(input int sel, input string tag, input logic [7:0] ev, input logic [2:0] ei);
        logic [10:0] ob, ex;
        ob = (sel != 0) ? {v1, iter1} : {v0, iter0};
        ex = {ev, ei};
        checks++;
        assert (ob === ex) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%b/%0d expected=%b/%0d", tag, sel, ob[10:3], ob[2:0], ev, ei);
        end
    endtask

    task automatic push(input logic [7:0] v, input int it, input bit chk, input int pass);
        step_t s;
        s.v = v; s.it = 3'(it); s.chk = chk; s.pass = pass;
        exp_q.push_back(s);
    endtask

    // Schedule of one run: k = pass on which single is seen at CHECK, 0 = never converges
    task automatic build(input int mc, input int mx, input int k);
        int p;
        bit to;
        exp_q.delete();
        push(8'b1000_0100, 0, 0, 0);
        push(8'b0100_0100, 0, 0, 0);
        p = 0;
        to = 0;
        forever begin
            p++;
            push(8'b0001_0100, p - 1, 0, p);
            for (int w = 1; w < mc; w++) push(8'b0000_0100, p - 1, 0, p);
            push(8'b0000_1100, p - 1, 0, p);
            push(8'b0000_0100, p, 1, p);
            if (p == k) break;
            if (p == mx) begin to = 1; break; end
            push(8'b0110_0100, p, 0, p);
        end
        push({7'b0000_001, to}, p, 0, 0);
        push({7'b0000_001, to}, p, 0, 0);
    endtask

    task automatic drive(input int sel, input logic st, input logic sg);
        if (sel != 0) begin start1 = st; single1 = sg; end
        else begin start0 = st; single0 = sg; end
    endtask

    // Entered and left at posedge+1; abort_at >= 0 asserts reset at that step
    task automatic run(input int sel, input int k, input int abort_at);
        build((sel != 0) ? 3 : 1, (sel != 0) ? 5 : 4, k);
        drive(sel, 1'b1, 1'($urandom_range(0, 1)));
        @(posedge clk); #1;
        foreach (exp_q[i]) begin
            if (i == abort_at) begin
                drive(sel, 1'b0, 1'b0);
                rst = 1'b0;
                #1;
                check(sel, "rst_mid_run", 8'h00, 3'd0);
                check(0, "rst_other", 8'h00, 3'd0);
                @(posedge clk); #1;
                rst = 1'b1;
                return;
            end
            drive(sel,
                  exp_q[i].v[2] ? 1'($urandom_range(0, 1)) : 1'b0,
                  exp_q[i].chk ? (exp_q[i].pass == k) : 1'($urandom_range(0, 1)));
            @(negedge clk);
            check(sel, exp_q[i].chk ? "check_state" : "step", exp_q[i].v, exp_q[i].it);
            @(posedge clk); #1;
        end
        drive(sel, 1'b0, 1'b0);
    endtask

    initial begin
        #12;
        check(0, "reset0", 8'h00, 3'd0);
        check(1, "reset1", 8'h00, 3'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check(0, "idle0", 8'h00, 3'd0);
            check(1, "idle1", 8'h00, 3'd0);
            @(posedge clk); #1;
        end

        run(0, 1, -1);
        run(0, 3, -1);
        run(0, 0, -1);
        run(0, 4, -1);
        for (int r = 0; r < 4; r++) run(0, int'($urandom_range(0, 4)), -1);

        run(1, 2, -1);
        run(1, 0, -1);
        run(1, 1, 4);
        @(negedge clk);
        check(0, "idle_after_rst0", 8'h00, 3'd0);
        check(1, "idle_after_rst1", 8'h00, 3'd0);
        @(posedge clk); #1;
        run(1, int'($urandom_range(1, 5)), -1);
        run(1, 5, -1);
        run(0, 2, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
